cache_bus_responder: RTL and testbench
======================================

Name: cache_bus_responder

Overview:
Bus-side responder for one L1 cache instance. It sits at the cac2bus/bus2cac end of the cache's bus interface and stands in for memory plus the rest of the coherence fabric. It answers the cache's bus requests with line data from a small backing memory, absorbs write-backs, and injects snoop requests into the cache from a command port. It is synthesizable and used as the bus-side agent in single-cache testbenches.

Parameters:
LINE_WIDTH, 64, cache line width in bits
ADDR_WIDTH, 32, byte address width; BLK_AW = ADDR_WIDTH - $clog2(LINE_WIDTH/8)
MEM_DEPTH, 16, backing lines (power of 2), indexed by blk_addr[$clog2(MEM_DEPTH)-1:0]
RSP_LATENCY, 2, cycles from request capture to response (>=1)
SNP_TIMEOUT, 8, max cycles to wait for the cache's snoop response

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cac2bus_bus_req  in  2  cache request: 00 NONE, 01 BUS_RD, 10 BUS_RDX, 11 BUS_UPGR
cac2bus_bus_rsp  in  2  cache snoop response: 00 NONE, 01 FLUSH (data valid), 10 HIT_NODATA, 11 MISS
cac2bus_addr  in  BLK_AW  line address for request, snoop response, or write-back
cac2bus_data  in  LINE_WIDTH  flush/write-back data
cac2bus_write_back  in  1  one-cycle write-back strobe
bus2cac_bus_req  out  2  snoop to cache, same encoding as cac2bus_bus_req
bus2cac_bus_rsp  out  2  response: 00 NONE, 01 DATA_EXCL, 10 DATA_SHARED, 11 ACK
bus2cac_addr  out  BLK_AW  snoop or response line address
bus2cac_data  out  LINE_WIDTH  response line data
shared_hint  in  1  sampled at request capture; 1 -> BUS_RD answered DATA_SHARED
snp_valid  in  1  snoop command valid
snp_ready  out  1  snoop command accepted when snp_valid & snp_ready
snp_req  in  2  snoop type (00 is illegal and ignored)
snp_addr  in  BLK_AW  snoop line address
snp_done  out  1  one-cycle pulse when the snoop completes
snp_rsp  out  2  cache response captured with snp_done (00 on timeout)
snp_timeout  out  1  one-cycle pulse with snp_done when the timeout expires

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, memory lines 0.
- FSM states: IDLE, REQ_LAT, RSP, REQ_DROP, SNP, SNP_WAIT.
- IDLE, cac2bus_bus_req != 00: capture req, addr, shared_hint; load counter = RSP_LATENCY-1; go to REQ_LAT. A cache request has priority over a snoop; snp_ready = 0 that cycle.
- REQ_LAT: decrement the counter; at 0 go to RSP.
- RSP, one cycle: drive bus2cac_bus_rsp, bus2cac_addr = captured addr.
  - BUS_RD: DATA_SHARED if hint, else DATA_EXCL, data = mem[idx].
  - BUS_RDX: DATA_EXCL with data.
  - BUS_UPGR: ACK, data 0.
  - Go to REQ_DROP.
- Response latency = RSP_LATENCY+1 cycles from the first req-asserted edge.
- REQ_DROP: wait until cac2bus_bus_req == 00, then go to IDLE. A request that is held high is never answered twice.
- IDLE with no request: snp_ready = 1. On snp_valid with snp_req != 00, capture and go to SNP.
- SNP: drive bus2cac_bus_req / bus2cac_addr; hold them through SNP_WAIT.
- SNP_WAIT: count cycles.
  - cac2bus_bus_rsp != 00: snp_done = 1, snp_rsp = value. If FLUSH, write cac2bus_data to mem[idx of snoop addr]. Drop the snoop outputs next cycle and return to IDLE.
  - Count reaches SNP_TIMEOUT: snp_done = 1, snp_timeout = 1, snp_rsp = 00, return to IDLE.
- Write-back: cac2bus_write_back accepted in any state and written to mem[idx] that cycle.
- Write-back in the RSP cycle to the same line: bypass; response data = cac2bus_data.
- Write-back and snoop FLUSH in the same cycle to the same line: the FLUSH data wins.
- Reset mid-operation: immediate return to reset values; a pending snoop produces no snp_done.

Decomposition:
- Shared package cache_bus_pkg holds:
  - bus_req_e (NONE/BUS_RD/BUS_RDX/BUS_UPGR)
  - bus_rsp_e (NONE/DATA_EXCL/DATA_SHARED/ACK)
  - snp_rsp_e (NONE/FLUSH/HIT_NODATA/MISS)
  - responder FSM state enum
- One sub-module, cache_bus_mem: MEM_DEPTH x LINE_WIDTH array with async-reset-to-zero, one write port, one combinational read port, and the write-back bypass mux.

Test Plan:
- Write-back addr 0x3, data 0xA5A5_0000_0000_5A5A, then BUS_RD 0x3 with hint=0 -> DATA_EXCL with that data exactly 3 cycles after req (RSP_LATENCY=2).
- BUS_RD 0x5 with hint=1 -> DATA_SHARED, data 0. BUS_UPGR 0x5 -> ACK, data 0. Req held 10 cycles -> exactly one response pulse.
- snp_valid, BUS_RDX 0x7; cache answers FLUSH with 0x1122334455667788 after 3 cycles -> snp_done, snp_rsp=01; a later BUS_RD 0x7 returns 0x1122334455667788.
- Snoop with no cache response -> snp_done and snp_timeout after 8 wait cycles, snp_rsp=00, bus2cac_bus_req back to 00.
- snp_valid and cac2bus_bus_req=BUS_RD in the same cycle -> snp_ready=0, request served first, snoop issued after req drops. Write-back 0x9 in the RSP cycle of BUS_RD 0x9 -> bypassed data returned.
- Assert rst during SNP_WAIT -> all outputs 0 asynchronously, no snp_done, memory cleared.

Source files
------------

// File: rtl/cache_bus_pkg.sv
// Shared encodings for the cache bus responder: bus request/response codes,
// snoop response codes and the responder FSM state set.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_UPGR = 2'b11
    } bus_req_e;

    typedef enum logic [1:0] {
        RSP_NONE    = 2'b00,
        DATA_EXCL   = 2'b01,
        DATA_SHARED = 2'b10,
        ACK         = 2'b11
    } bus_rsp_e;

    typedef enum logic [1:0] {
        SNP_NONE   = 2'b00,
        FLUSH      = 2'b01,
        HIT_NODATA = 2'b10,
        MISS       = 2'b11
    } snp_rsp_e;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ_LAT  = 3'd1;
    localparam logic [2:0] ST_RSP      = 3'd2;
    localparam logic [2:0] ST_REQ_DROP = 3'd3;
    localparam logic [2:0] ST_SNP      = 3'd4;
    localparam logic [2:0] ST_SNP_WAIT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_REQ_LAT  = ST_REQ_LAT,
        S_RSP      = ST_RSP,
        S_REQ_DROP = ST_REQ_DROP,
        S_SNP      = ST_SNP,
        S_SNP_WAIT = ST_SNP_WAIT
    } rsp_state_e;

endpackage

// File: rtl/cache_bus_mem.sv
// Backing line store for the responder: reset-to-zero array, write-back and
// snoop-flush write lanes sharing one data bus, and a combinational read port.
module cache_bus_mem
    import cache_bus_pkg::*;
#(
    parameter  int LINE_WIDTH = 64,
    parameter  int MEM_DEPTH  = 16,
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LINE_WIDTH-1:0] wr_data,
    input  logic                  wb_en,
    input  logic [IDX_W-1:0]      wb_idx,
    input  logic                  flush_en,
    input  logic [IDX_W-1:0]      flush_idx,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [LINE_WIDTH-1:0] rd_data
);

    logic [LINE_WIDTH-1:0] mem [MEM_DEPTH];

    // Flush is applied last so it wins when both lanes hit the same line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wb_en) begin
                mem[wb_idx] <= wr_data;
            end
            if (flush_en) begin
                mem[flush_idx] <= wr_data;
            end
        end
    end

    // A write-back landing on the line being read is forwarded this cycle.
    always_comb begin
        rd_data = mem[rd_idx];
        if (wb_en && (wb_idx == rd_idx)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/cache_bus_responder.sv
// Bus-side agent for a single L1 cache: serves line requests from a backing
// store, absorbs write-backs, and injects snoops from a command port.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no transaction; requests win over snoop commands
// REQ_LAT    | request captured, counting down response latency
// RSP        | response registered onto bus2cac at the end of this cycle
// REQ_DROP   | response sent, waiting for the cache to drop its request
// SNP        | snoop driven to the cache
// SNP_WAIT   | snoop held, waiting for cache response or timeout
module cache_bus_responder
    import cache_bus_pkg::*;
#(
    parameter  int LINE_WIDTH  = 64,
    parameter  int ADDR_WIDTH  = 32,
    parameter  int MEM_DEPTH   = 16,
    parameter  int RSP_LATENCY = 2,
    parameter  int SNP_TIMEOUT = 8,
    localparam int BLK_AW      = ADDR_WIDTH - $clog2(LINE_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cac2bus_bus_req,
    input  logic [1:0]            cac2bus_bus_rsp,
    input  logic [BLK_AW-1:0]     cac2bus_addr,
    input  logic [LINE_WIDTH-1:0] cac2bus_data,
    input  logic                  cac2bus_write_back,
    output logic [1:0]            bus2cac_bus_req,
    output logic [1:0]            bus2cac_bus_rsp,
    output logic [BLK_AW-1:0]     bus2cac_addr,
    output logic [LINE_WIDTH-1:0] bus2cac_data,
    input  logic                  shared_hint,
    input  logic                  snp_valid,
    output logic                  snp_ready,
    input  logic [1:0]            snp_req,
    input  logic [BLK_AW-1:0]     snp_addr,
    output logic                  snp_done,
    output logic [1:0]            snp_rsp,
    output logic                  snp_timeout
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LAT_W = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
    localparam int TO_W  = (SNP_TIMEOUT > 1) ? $clog2(SNP_TIMEOUT) : 1;

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RSP_LATENCY - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(SNP_TIMEOUT - 1);

    rsp_state_e            state;
    bus_req_e              req_type;
    logic [BLK_AW-1:0]     req_addr;
    logic                  req_hint;
    logic [LAT_W-1:0]      lat_cnt;
    logic [TO_W-1:0]       wait_cnt;
    logic [IDX_W-1:0]      snp_idx;
    logic                  flush_en;
    logic [LINE_WIDTH-1:0] rd_data;

    assign snp_ready = !rst && (state == S_IDLE) && (cac2bus_bus_req == REQ_NONE);
    assign flush_en  = (state == S_SNP_WAIT) && (snp_rsp_e'(cac2bus_bus_rsp) == FLUSH);

    cache_bus_mem #(
        .LINE_WIDTH (LINE_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (cac2bus_data),
        .wb_en     (cac2bus_write_back),
        .wb_idx    (cac2bus_addr[IDX_W-1:0]),
        .flush_en  (flush_en),
        .flush_idx (snp_idx),
        .rd_idx    (req_addr[IDX_W-1:0]),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            req_type        <= REQ_NONE;
            req_addr        <= '0;
            req_hint        <= 1'b0;
            lat_cnt         <= '0;
            wait_cnt        <= '0;
            snp_idx         <= '0;
            bus2cac_bus_req <= REQ_NONE;
            bus2cac_bus_rsp <= RSP_NONE;
            bus2cac_addr    <= '0;
            bus2cac_data    <= '0;
            snp_done        <= 1'b0;
            snp_rsp         <= SNP_NONE;
            snp_timeout     <= 1'b0;
        end else begin
            bus2cac_bus_rsp <= RSP_NONE;
            bus2cac_data    <= '0;
            snp_done        <= 1'b0;
            snp_rsp         <= SNP_NONE;
            snp_timeout     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cac2bus_bus_req != REQ_NONE) begin
                        req_type <= bus_req_e'(cac2bus_bus_req);
                        req_addr <= cac2bus_addr;
                        req_hint <= shared_hint;
                        lat_cnt  <= LAT_LOAD;
                        state    <= S_REQ_LAT;
                    end else if (snp_valid && (snp_req != REQ_NONE)) begin
                        bus2cac_bus_req <= snp_req;
                        bus2cac_addr    <= snp_addr;
                        snp_idx         <= snp_addr[IDX_W-1:0];
                        state           <= S_SNP;
                    end
                end

                S_REQ_LAT: begin
                    if (lat_cnt == '0) begin
                        state <= S_RSP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                S_RSP: begin
                    bus2cac_addr <= req_addr;
                    case (req_type)
                        BUS_RD: begin
                            bus2cac_bus_rsp <= req_hint ? DATA_SHARED : DATA_EXCL;
                            bus2cac_data    <= rd_data;
                        end
                        BUS_RDX: begin
                            bus2cac_bus_rsp <= DATA_EXCL;
                            bus2cac_data    <= rd_data;
                        end
                        default: begin
                            bus2cac_bus_rsp <= ACK;
                        end
                    endcase
                    state <= S_REQ_DROP;
                end

                // Waiting for the drop keeps a held request from being served twice.
                S_REQ_DROP: begin
                    bus2cac_addr <= '0;
                    if (cac2bus_bus_req == REQ_NONE) begin
                        state <= S_IDLE;
                    end
                end

                S_SNP: begin
                    wait_cnt <= '0;
                    state    <= S_SNP_WAIT;
                end

                S_SNP_WAIT: begin
                    if (cac2bus_bus_rsp != SNP_NONE) begin
                        snp_done        <= 1'b1;
                        snp_rsp         <= cac2bus_bus_rsp;
                        bus2cac_bus_req <= REQ_NONE;
                        bus2cac_addr    <= '0;
                        wait_cnt        <= '0;
                        state           <= S_IDLE;
                    end else if (wait_cnt == TO_LAST) begin
                        snp_done        <= 1'b1;
                        snp_timeout     <= 1'b1;
                        bus2cac_bus_req <= REQ_NONE;
                        bus2cac_addr    <= '0;
                        wait_cnt        <= '0;
                        state           <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_responder.sv
// Directed bench for cache_bus_responder: requests, latency, held requests,
// snoop flush/miss/timeout, request-over-snoop priority, bypass and reset.
module tb_cache_bus_responder;

    localparam int LW          = 64;
    localparam int BLK_AW      = 29;
    localparam int RSP_LATENCY = 2;
    localparam int SNP_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        cac2bus_bus_req = '0;
    logic [1:0]        cac2bus_bus_rsp = '0;
    logic [BLK_AW-1:0] cac2bus_addr = '0;
    logic [LW-1:0]     cac2bus_data = '0;
    logic              cac2bus_write_back = 1'b0;
    logic [1:0]        bus2cac_bus_req;
    logic [1:0]        bus2cac_bus_rsp;
    logic [BLK_AW-1:0] bus2cac_addr;
    logic [LW-1:0]     bus2cac_data;
    logic              shared_hint = 1'b0;
    logic              snp_valid = 1'b0;
    logic              snp_ready;
    logic [1:0]        snp_req = '0;
    logic [BLK_AW-1:0] snp_addr = '0;
    logic              snp_done;
    logic [1:0]        snp_rsp;
    logic              snp_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_bus_responder #(
        .LINE_WIDTH  (LW),
        .ADDR_WIDTH  (32),
        .MEM_DEPTH   (16),
        .RSP_LATENCY (RSP_LATENCY),
        .SNP_TIMEOUT (SNP_TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cac2bus_bus_req    (cac2bus_bus_req),
        .cac2bus_bus_rsp    (cac2bus_bus_rsp),
        .cac2bus_addr       (cac2bus_addr),
        .cac2bus_data       (cac2bus_data),
        .cac2bus_write_back (cac2bus_write_back),
        .bus2cac_bus_req    (bus2cac_bus_req),
        .bus2cac_bus_rsp    (bus2cac_bus_rsp),
        .bus2cac_addr       (bus2cac_addr),
        .bus2cac_data       (bus2cac_data),
        .shared_hint        (shared_hint),
        .snp_valid          (snp_valid),
        .snp_ready          (snp_ready),
        .snp_req            (snp_req),
        .snp_addr           (snp_addr),
        .snp_done           (snp_done),
        .snp_rsp            (snp_rsp),
        .snp_timeout        (snp_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request, optionally write back the same line in the RSP cycle,
    // and check the response appears exactly RSP_LATENCY+1 edges after capture.
    task automatic do_req(input string tag, input logic [1:0] typ, input logic [BLK_AW-1:0] a,
                          input logic h, input logic wb, input logic [LW-1:0] wbd,
                          input logic [1:0] exp_rsp, input logic [LW-1:0] exp_data);
        cac2bus_bus_req = typ;
        cac2bus_addr    = a;
        shared_hint     = h;
        #1;
        chk({tag, "_snp_ready_low"}, 64'(snp_ready), 64'd0);
        tick();
        shared_hint = ~h;
        for (int c = 1; c <= RSP_LATENCY + 1; c++) begin
            tick();
            if (c <= RSP_LATENCY) begin
                chk({tag, "_early_rsp"}, 64'(bus2cac_bus_rsp), 64'd0);
            end
            if (c == RSP_LATENCY && wb) begin
                cac2bus_write_back = 1'b1;
                cac2bus_data       = wbd;
            end
        end
        cac2bus_write_back = 1'b0;
        chk({tag, "_rsp"}, 64'(bus2cac_bus_rsp), 64'(exp_rsp));
        chk({tag, "_data"}, bus2cac_data, exp_data);
        chk({tag, "_addr"}, 64'(bus2cac_addr), 64'(a));
        chk({tag, "_no_snoop"}, 64'(bus2cac_bus_req), 64'd0);
        cac2bus_bus_req = 2'b00;
        shared_hint     = 1'b0;
        tick();
        chk({tag, "_rsp_cleared"}, 64'(bus2cac_bus_rsp), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        logic bad;
        logic got;

        tick();
        tick();
        chk("rst_bus2cac_req", 64'(bus2cac_bus_req), 64'd0);
        chk("rst_bus2cac_rsp", 64'(bus2cac_bus_rsp), 64'd0);
        chk("rst_bus2cac_data", bus2cac_data, 64'd0);
        chk("rst_snp_ready", 64'(snp_ready), 64'd0);
        chk("rst_snp_done", 64'(snp_done), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_snp_ready", 64'(snp_ready), 64'd1);

        // write-back then read it back exclusively
        cac2bus_addr       = 29'h3;
        cac2bus_data       = 64'hA5A5_0000_0000_5A5A;
        cac2bus_write_back = 1'b1;
        tick();
        cac2bus_write_back = 1'b0;
        do_req("rd3", 2'b01, 29'h3, 1'b0, 1'b0, 64'd0, 2'b01, 64'hA5A5_0000_0000_5A5A);
        do_req("rd5_shared", 2'b01, 29'h5, 1'b1, 1'b0, 64'd0, 2'b10, 64'd0);
        do_req("upgr3", 2'b11, 29'h3, 1'b0, 1'b0, 64'd0, 2'b11, 64'd0);
        do_req("rdx3", 2'b10, 29'h3, 1'b1, 1'b0, 64'd0, 2'b01, 64'hA5A5_0000_0000_5A5A);

        // request held for 10 cycles is answered once
        cac2bus_bus_req = 2'b01;
        cac2bus_addr    = 29'h5;
        pulses = 0;
        repeat (10) begin
            tick();
            if (bus2cac_bus_rsp != 2'b00) pulses++;
        end
        chk("held_pulses", 64'(pulses), 64'd1);
        cac2bus_bus_req = 2'b00;
        tick();

        // snoop answered with FLUSH updates the backing line
        snp_valid = 1'b1;
        snp_req   = 2'b10;
        snp_addr  = 29'h7;
        #1;
        chk("snp7_ready", 64'(snp_ready), 64'd1);
        tick();
        snp_valid = 1'b0;
        chk("snp7_req", 64'(bus2cac_bus_req), 64'd2);
        chk("snp7_addr", 64'(bus2cac_addr), 64'd7);
        tick();
        tick();
        chk("snp7_hold", 64'(bus2cac_bus_req), 64'd2);
        cac2bus_bus_rsp = 2'b01;
        cac2bus_addr    = 29'h7;
        cac2bus_data    = 64'h1122_3344_5566_7788;
        tick();
        cac2bus_bus_rsp = 2'b00;
        chk("snp7_done", 64'(snp_done), 64'd1);
        chk("snp7_rsp", 64'(snp_rsp), 64'd1);
        chk("snp7_timeout", 64'(snp_timeout), 64'd0);
        chk("snp7_req_dropped", 64'(bus2cac_bus_req), 64'd0);
        tick();
        chk("snp7_done_pulse", 64'(snp_done), 64'd0);
        do_req("rd7", 2'b01, 29'h7, 1'b0, 1'b0, 64'd0, 2'b01, 64'h1122_3344_5566_7788);

        // snoop type 00 is ignored
        snp_valid = 1'b1;
        snp_req   = 2'b00;
        snp_addr  = 29'h1;
        tick();
        snp_valid = 1'b0;
        chk("illegal_snp_req", 64'(bus2cac_bus_req), 64'd0);
        chk("illegal_snp_idle", 64'(snp_ready), 64'd1);

        // snoop without a cache answer times out
        snp_valid = 1'b1;
        snp_req   = 2'b01;
        snp_addr  = 29'hA;
        tick();
        snp_valid = 1'b0;
        cyc = 0;
        bad = 1'b0;
        while (cyc < 20 && !snp_done) begin
            if (bus2cac_bus_req != 2'b01) bad = 1'b1;
            tick();
            cyc++;
        end
        chk("to_cycles", 64'(cyc), 64'(SNP_TIMEOUT + 1));
        chk("to_req_held", 64'(bad), 64'd0);
        chk("to_flag", 64'(snp_timeout), 64'd1);
        chk("to_rsp", 64'(snp_rsp), 64'd0);
        chk("to_req_dropped", 64'(bus2cac_bus_req), 64'd0);
        tick();
        chk("to_flag_pulse", 64'(snp_timeout), 64'd0);

        // request beats a simultaneous snoop; write-back in RSP is bypassed
        snp_valid = 1'b1;
        snp_req   = 2'b01;
        snp_addr  = 29'hB;
        do_req("rd9_bypass", 2'b01, 29'h9, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D,
               2'b01, 64'hDEAD_BEEF_CAFE_F00D);
        chk("prio_snp_ready", 64'(snp_ready), 64'd1);
        tick();
        snp_valid = 1'b0;
        chk("prio_snp_req", 64'(bus2cac_bus_req), 64'd1);
        chk("prio_snp_addr", 64'(bus2cac_addr), 64'hB);
        tick();
        cac2bus_bus_rsp = 2'b11;
        tick();
        cac2bus_bus_rsp = 2'b00;
        chk("prio_snp_done", 64'(snp_done), 64'd1);
        chk("prio_snp_rsp", 64'(snp_rsp), 64'd3);
        do_req("rd9", 2'b01, 29'h9, 1'b0, 1'b0, 64'd0, 2'b01, 64'hDEAD_BEEF_CAFE_F00D);
        do_req("rdB_miss", 2'b01, 29'hB, 1'b0, 1'b0, 64'd0, 2'b01, 64'd0);

        // reset in the middle of a snoop
        snp_valid = 1'b1;
        snp_req   = 2'b10;
        snp_addr  = 29'h3;
        tick();
        snp_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req", 64'(bus2cac_bus_req), 64'd0);
        chk("midrst_addr", 64'(bus2cac_addr), 64'd0);
        chk("midrst_snp_ready", 64'(snp_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        got = 1'b0;
        repeat (12) begin
            tick();
            if (snp_done) got = 1'b1;
        end
        chk("midrst_no_done", 64'(got), 64'd0);
        do_req("rst_rd3", 2'b01, 29'h3, 1'b0, 1'b0, 64'd0, 2'b01, 64'd0);
        do_req("rst_rd7", 2'b01, 29'h7, 1'b0, 1'b0, 64'd0, 2'b01, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
